// File: rtl/floating_multiplication.sv
// Two-stage pipelined IEEE-754 binary32 multiplier (flush-to-zero, round-to-nearest-even).
// Define FMUL_FLAGS_EN to add the exception flag outputs aligned with out_valid.
module floating_multiplication #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] result
`ifdef FMUL_FLAGS_EN
    ,
    output logic             flag_invalid,
    output logic             flag_overflow,
    output logic             flag_underflow,
    output logic             flag_inexact
`endif
);

    localparam logic [WIDTH-1:0] QNAN = 32'h7FC0_0000;

    // ---------------------------------------------------------------
    // Stage 1: unpack and classify both operands, multiply significands
    // ---------------------------------------------------------------
    logic [1:0][WIDTH-1:0] opnd;
    logic [1:0]            op_sign;
    logic [1:0][7:0]       op_exp;
    logic [1:0][23:0]      op_sig;
    logic [1:0]            op_zero;
    logic [1:0]            op_inf;
    logic [1:0]            op_nan;

    assign opnd = {B, A};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign op_sign[gi] = opnd[gi][31];
            assign op_exp[gi]  = opnd[gi][30:23];
            assign op_sig[gi]  = {1'b1, opnd[gi][22:0]};
            // Exponent 0 covers both true zero and flushed subnormals.
            assign op_zero[gi] = (op_exp[gi] == 8'h00);
            assign op_inf[gi]  = (op_exp[gi] == 8'hFF) && (opnd[gi][22:0] == 23'h0);
            assign op_nan[gi]  = (op_exp[gi] == 8'hFF) && (opnd[gi][22:0] != 23'h0);
        end
    endgenerate

    logic               sign_next;
    logic signed [9:0]  exp_next;
    logic [47:0]        prod_next;
    logic               nan_next;
    logic               inf_next;
    logic               zero_next;

    always_comb begin
        sign_next = ^op_sign;
        exp_next  = $signed({2'b00, op_exp[0]} + {2'b00, op_exp[1]}) - 10'sd127;
        prod_next = op_sig[0] * op_sig[1];
        // Inf x 0 folds into the NaN class: both produce the canonical quiet NaN.
        nan_next  = |op_nan
                  | (op_inf[0] & op_zero[1])
                  | (op_zero[0] & op_inf[1]);
        inf_next  = |op_inf;
        zero_next = |op_zero;
    end

    logic               s1_valid_reg;
    logic               s1_sign_reg;
    logic signed [9:0]  s1_exp_reg;
    logic [47:0]        s1_prod_reg;
    logic               s1_nan_reg;
    logic               s1_inf_reg;
    logic               s1_zero_reg;

    // ---------------------------------------------------------------
    // Stage 2: normalise, round to nearest even, range check, pack
    // ---------------------------------------------------------------
    logic [23:0]        norm_sig;
    logic               guard;
    logic               sticky;
    logic signed [9:0]  norm_exp;
    logic               round_up;
    logic [24:0]        round_sig;
    logic signed [9:0]  final_exp;
    logic [22:0]        final_frac;
    logic               exp_high;
    logic               exp_low;
    logic [WIDTH-1:0]   result_next;

    always_comb begin
        if (s1_prod_reg[47]) begin
            norm_sig = s1_prod_reg[47:24];
            guard    = s1_prod_reg[23];
            sticky   = |s1_prod_reg[22:0];
            norm_exp = s1_exp_reg + 10'sd1;
        end else begin
            norm_sig = s1_prod_reg[46:23];
            guard    = s1_prod_reg[22];
            sticky   = |s1_prod_reg[21:0];
            norm_exp = s1_exp_reg;
        end

        round_up  = guard & (sticky | norm_sig[0]);
        round_sig = {1'b0, norm_sig} + {24'd0, round_up};
        // A rounding carry out of the significand bumps the exponent; fraction becomes zero.
        final_exp  = norm_exp + $signed({9'd0, round_sig[24]});
        final_frac = round_sig[24] ? round_sig[23:1] : round_sig[22:0];

        exp_high = (final_exp >= 10'sd255);
        exp_low  = (final_exp <= 10'sd0);

        if (s1_nan_reg) begin
            result_next = QNAN;
        end else if (s1_inf_reg) begin
            result_next = {s1_sign_reg, 8'hFF, 23'h0};
        end else if (s1_zero_reg) begin
            result_next = {s1_sign_reg, 31'h0};
        end else if (exp_high) begin
            result_next = {s1_sign_reg, 8'hFF, 23'h0};
        end else if (exp_low) begin
            result_next = {s1_sign_reg, 31'h0};
        end else begin
            result_next = {s1_sign_reg, final_exp[7:0], final_frac};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_exp_reg   <= '0;
            s1_prod_reg  <= '0;
            s1_nan_reg   <= 1'b0;
            s1_inf_reg   <= 1'b0;
            s1_zero_reg  <= 1'b0;
            out_valid    <= 1'b0;
            result       <= '0;
        end else begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sign_reg <= sign_next;
                s1_exp_reg  <= exp_next;
                s1_prod_reg <= prod_next;
                s1_nan_reg  <= nan_next;
                s1_inf_reg  <= inf_next;
                s1_zero_reg <= zero_next;
            end
            out_valid <= s1_valid_reg;
            // Bubbles leave the previous result on the output.
            if (s1_valid_reg) begin
                result <= result_next;
            end
        end
    end

`ifdef FMUL_FLAGS_EN
    logic normal_path;
    logic invalid_next;
    logic overflow_next;
    logic underflow_next;
    logic inexact_next;

    always_comb begin
        normal_path    = ~s1_nan_reg & ~s1_inf_reg & ~s1_zero_reg;
        invalid_next   = s1_nan_reg;
        overflow_next  = normal_path & exp_high;
        underflow_next = normal_path & exp_low;
        inexact_next   = normal_path & (guard | sticky | exp_high | exp_low);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else begin
            flag_invalid   <= s1_valid_reg & invalid_next;
            flag_overflow  <= s1_valid_reg & overflow_next;
            flag_underflow <= s1_valid_reg & underflow_next;
            flag_inexact   <= s1_valid_reg & inexact_next;
        end
    end
`endif

endmodule

// File: tb/tb_floating_multiplication.sv
// Self-checking bench for floating_multiplication: directed vectors, back-to-back ops,
// mid-flight reset, then randomized operands against an arithmetic reference model.
module tb_floating_multiplication;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic [31:0] result;
`ifdef FMUL_FLAGS_EN
    logic        flag_invalid;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;
`endif

    floating_multiplication #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .result    (result)
`ifdef FMUL_FLAGS_EN
        ,
        .flag_invalid   (flag_invalid),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow),
        .flag_inexact   (flag_inexact)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected output state and the op currently sitting in the first pipeline stage.
    logic        exp_valid;
    logic [31:0] exp_result;
    logic [3:0]  exp_flags;
    logic        pend_v;
    logic [35:0] pend;
    logic [31:0] pend_a;
    logic [31:0] pend_b;

    // Returns {invalid, overflow, underflow, inexact, result}.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sign;
        int          ea, eb, s, e;
        logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        longint unsigned p, q, rem, half;
        sign   = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            return {4'b1000, 32'h7FC0_0000};
        if (a_inf || b_inf)
            return {4'b0000, sign, 8'hFF, 23'h0};
        if (a_zero || b_zero)
            return {4'b0000, sign, 31'h0};
        // Exact integer product of the significands, then keep the top 24 bits.
        p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        s = 0;
        while ((p >> s) >= 64'd16777216) s++;
        q    = p >> s;
        rem  = p - (q << s);
        half = 64'd1 << (s - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == 64'd16777216) begin
            q = q >> 1;
            s = s + 1;
        end
        e = ea + eb - 150 + s;
        if (e >= 255)
            return {4'b0101, sign, 8'hFF, 23'h0};
        if (e <= 0)
            return {4'b0011, sign, 31'h0};
        return {3'b000, (rem != 0), sign, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        int          cls;
        r   = $urandom;
        cls = int'($urandom_range(0, 15));
        case (cls)
            0:       r[30:0] = 31'h0;
            1:       r[30:0] = {8'hFF, 23'h0};
            2:       r[30:23] = 8'hFF;
            3:       r[30:23] = 8'h00;
            4:       r[30:23] = 8'(240 + $urandom_range(0, 14));
            5:       r[30:23] = 8'(1 + $urandom_range(0, 40));
            6:       r[11:0] = 12'h0;
            default: r[30:23] = 8'(100 + $urandom_range(0, 54));
        endcase
        if (cls == 2 && r[22:0] == 23'h0) r[0] = 1'b1;
        return r;
    endfunction

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    // One clock: drive inputs, advance, update model, compare every output.
    task automatic step(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic use_want, input logic [31:0] want);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
        if (r) begin
            exp_valid  = 1'b0;
            exp_result = 32'h0;
            exp_flags  = 4'h0;
            pend_v     = 1'b0;
        end else begin
            exp_valid = pend_v;
            if (pend_v) begin
                exp_result = pend[31:0];
                exp_flags  = pend[35:32];
            end else begin
                exp_flags = 4'h0;
            end
            pend_v = v;
            if (v) begin
                pend   = ref_mul(a, b);
                if (use_want) pend[31:0] = want;
                pend_a = a;
                pend_b = b;
            end
        end
        check32("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
        check32("result", result, exp_result);
`ifdef FMUL_FLAGS_EN
        check32("flags", {28'h0, flag_invalid, flag_overflow, flag_underflow, flag_inexact},
                {28'h0, exp_flags});
`endif
        if (exp_valid)
            $display("op %h x %h -> %h (expected %h)", pend_a, pend_b, result, exp_result);
    endtask

    localparam logic [31:0] DA [7] = '{32'h40600000, 32'h413C0000, 32'h3FA00000, 32'h7F800000,
                                       32'h7F000000, 32'h00800000, 32'h80000000};
    localparam logic [31:0] DB [7] = '{32'h40900000, 32'h4019999A, 32'hC0E9999A, 32'h00000000,
                                       32'h7F000000, 32'h00800000, 32'h3F800000};
    localparam logic [31:0] DR [7] = '{32'h417C0000, 32'h41E1999A, 32'hC1120000, 32'h7FC00000,
                                       32'h7F800000, 32'h00000000, 32'h80000000};

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = 32'h0; B = 32'h0;
        exp_valid = 1'b0; exp_result = 32'h0; exp_flags = 4'h0;
        pend_v = 1'b0; pend = 36'h0; pend_a = 32'h0; pend_b = 32'h0;

        // Reset state
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        // Directed vectors, each followed by a bubble so result-hold is exercised
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, DA[i], DB[i], 1'b1, DR[i]);
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        end

        // Four back-to-back ops
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 32'h3F800000 + 32'($urandom_range(0, 32'h7FFFFF)),
                 32'h40000000 + 32'($urandom_range(0, 32'h7FFFFF)), 1'b0, 32'h0);
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        // Reset with ops in flight: nothing stale may emerge afterwards
        step(1'b0, 1'b1, 32'h40600000, 32'h40900000, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h413C0000, 32'h4019999A, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h3FA00000, 32'hC0E9999A, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        // Randomized traffic with occasional bubbles
        for (int i = 0; i < 400; i++)
            step(1'b0, ($urandom_range(0, 4) != 0), rand_operand(), rand_operand(), 1'b0, 32'h0);
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
